// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one pipelined cordic magnitude unit among N_REQ
// clients. An id tag pipeline matched to the cordic depth routes each result back home.
module cordic_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int Q_I     = 15,
  parameter int Q_F     = 16,
  parameter int LATENCY = 18,
  localparam int W      = Q_I + Q_F + 1,
  localparam int CNT_W  = $clog2(LATENCY + 2),
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_x_i,
  input  logic [N_REQ*W-1:0] req_y_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [W-1:0]       rsp_data_o,
  output logic               cdc_valid_o,
  output logic [W-1:0]       cdc_x_o,
  output logic [W-1:0]       cdc_y_o,
  input  logic               cdc_valid_i,
  input  logic [W-1:0]       cdc_data_i,
  output logic [CNT_W-1:0]   inflight_o,
  output logic               err_o
);

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;

  logic [IDW-1:0]   issue_id_q;

  logic [LATENCY-1:0]           tag_v_q;
  logic [LATENCY-1:0][IDW-1:0]  tag_id_q;
  logic                         tail_v;
  logic [IDW-1:0]               tail_id;

  logic [N_REQ-1:0] rsp_valid_d;
  logic             rsp_fire;
  logic             misalign;

  logic [CNT_W-1:0] inflight_q;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_any) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      if (grant_id == IDW'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Issue register: operands hold their last value when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cdc_valid_o <= 1'b0;
      cdc_x_o     <= '0;
      cdc_y_o     <= '0;
      issue_id_q  <= '0;
    end else begin
      cdc_valid_o <= grant_any;
      if (grant_any) begin
        cdc_x_o    <= req_x_i[grant_id*W +: W];
        cdc_y_o    <= req_y_i[grant_id*W +: W];
        issue_id_q <= grant_id;
      end
    end
  end

  // Tag pipeline, one entry per cordic stage; the tail lines up with cdc_valid_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q  <= {tag_v_q[LATENCY-2:0], cdc_valid_o};
      tag_id_q <= {tag_id_q[LATENCY-2:0], issue_id_q};
    end
  end

  assign tail_v   = tag_v_q[LATENCY-1];
  assign tail_id  = tag_id_q[LATENCY-1];
  assign rsp_fire = cdc_valid_i && tail_v;
  assign misalign = cdc_valid_i != tail_v;

  always_comb begin
    rsp_valid_d = '0;
    if (rsp_fire) begin
      rsp_valid_d[tail_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= rsp_valid_d;
      if (rsp_fire) begin
        rsp_data_o <= cdc_data_i;
      end
    end
  end

  // A result arriving without a tag, or a tag without a result, is unrecoverable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (misalign) begin
      err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      unique case ({grant_any, tail_v})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight_o = inflight_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler; the bench itself acts as the cordic, a real-valued
// magnitude stub with a programmable extra cycle of delay.
module tb_cordic_rr_scheduler;
  localparam int N_REQ   = 4;
  localparam int Q_I     = 15;
  localparam int Q_F     = 16;
  localparam int W       = Q_I + Q_F + 1;
  localparam int LATENCY = 18;
  localparam int CNT_W   = $clog2(LATENCY + 2);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_x = '0;
  logic [N_REQ*W-1:0] req_y = '0;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_data;
  logic               cdc_valid_o;
  logic [W-1:0]       cdc_x;
  logic [W-1:0]       cdc_y;
  logic               cdc_valid_i;
  logic [W-1:0]       cdc_data;
  logic [CNT_W-1:0]   inflight;
  logic               err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stub_extra = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_rr_scheduler #(
    .N_REQ(N_REQ), .Q_I(Q_I), .Q_F(Q_F), .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .cdc_valid_o(cdc_valid_o), .cdc_x_o(cdc_x), .cdc_y_o(cdc_y),
    .cdc_valid_i(cdc_valid_i), .cdc_data_i(cdc_data),
    .inflight_o(inflight), .err_o(err)
  );

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic [W-1:0] y);
    real xr, yr, m;
    xr = $itor($signed(x)) / 65536.0;
    yr = $itor($signed(y)) / 65536.0;
    m  = $sqrt(xr * xr + yr * yr);
    return W'($rtoi(m * 65536.0 + 0.5));
  endfunction

  // Cordic stand-in: delay line of LATENCY (+1 when misaligned) stages, shares reset.
  logic         sv [LATENCY+1];
  logic [W-1:0] sd [LATENCY+1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
      end
    end else begin
      sv[0] <= cdc_valid_o;
      sd[0] <= mag(cdc_x, cdc_y);
      for (int i = 1; i <= LATENCY; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sd[i-1];
      end
    end
  end
  assign cdc_valid_i = (stub_extra != 0) ? sv[LATENCY] : sv[LATENCY-1];
  assign cdc_data    = (stub_extra != 0) ? sd[LATENCY] : sd[LATENCY-1];

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           cyc;
  } rsp_t;
  rsp_t rsp_q[$];
  int   rsp_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      rsp_t r;
      r.id = ($countones(rsp_valid) == 1) ? -2 : -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (r.id == -2 && rsp_valid[k]) r.id = k;
      end
      r.data = rsp_data;
      r.cyc  = cyc;
      rsp_q.push_back(r);
      rsp_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rsp_q.delete();
  endtask

  function automatic logic [W-1:0] val(input int k, input int n);
    return W'((k * 16 + n + 1) << 16);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int cnt [N_REQ];
    int seen [N_REQ];
    rsp_t r;
    int base;
    int diff;

    // Reset state
    do_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_cdc_valid", cdc_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);

    // 1: single request from requester 2, 3+4j -> 5.0
    @(negedge clk);
    req_x[2*W +: W] = 32'h0003_0000;
    req_y[2*W +: W] = 32'h0004_0000;
    req_valid = 4'b0100;
    #1;
    chk("t1_grant", req_ready, 4'b0100);
    c0 = cyc;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_issue_valid", cdc_valid_o, 1);
    chk("t1_issue_x", cdc_x, 32'h0003_0000);
    for (int i = 0; i < 60 && rsp_q.size() == 0; i++) @(negedge clk);
    #1;
    chk("t1_rsp_seen", rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("t1_rsp_id", r.id, 2);
      chk("t1_rsp_latency", r.cyc - c0, LATENCY + 2);
      diff = int'(r.data) - 32'h0005_0000;
      chk("t1_rsp_close", (diff <= 64 && diff >= -64), 1);
    end

    // 2: all four requesters saturating for 40 cycles
    do_reset();
    for (int k = 0; k < N_REQ; k++) begin
      cnt[k] = 0;
      seen[k] = 0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int k = 0; k < N_REQ; k++) req_x[k*W +: W] = val(k, cnt[k]);
      req_valid = 4'hF;
      #1;
      chk("t2_grant", req_ready, 64'(1 << (i % 4)));
      for (int k = 0; k < N_REQ; k++) if (req_ready[k]) cnt[k]++;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LATENCY + 6) @(negedge clk);
    #1;
    while (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      if (r.id < 0 || r.id >= N_REQ) begin
        chk("t2_onehot", r.id, 0);
      end else begin
        chk("t2_route", r.data, val(r.id, seen[r.id]));
        seen[r.id]++;
      end
    end
    for (int k = 0; k < N_REQ; k++) chk("t2_count", seen[k], 10);

    // 3: requesters 1 and 3 with pointer at 2
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("t3_setup", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    chk("t3_grant_a", req_ready, 4'b1000);
    @(negedge clk);
    #1;
    chk("t3_grant_b", req_ready, 4'b0010);
    @(negedge clk);
    #1;
    chk("t3_grant_c", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    repeat (LATENCY + 6) @(negedge clk);

    // 4: cordic returns one cycle late
    stub_extra = 1;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    c0 = cyc;
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 60 && cyc < c0 + LATENCY + 1; i++) @(negedge clk);
    #1;
    chk("t4_err_before", err, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t4_err_set", err, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("t4_err_sticky", err, 1);
    chk("t4_no_rsp", rsp_q.size(), 0);

    // 5: reset with five operations in flight
    stub_extra = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < N_REQ; k++) req_x[k*W +: W] = val(k, i);
      req_valid = 4'hF;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_inflight", inflight, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_cdc_valid", cdc_valid_o, 0);
    chk("t5_async_cdc_x", cdc_x, 0);
    chk("t5_async_cdc_y", cdc_y, 0);
    chk("t5_async_rsp", rsp_valid, 0);
    chk("t5_async_inflight", inflight, 0);
    chk("t5_async_ready", req_ready, 0);
    chk("t5_async_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = rsp_cnt;
    repeat (LATENCY + 8) @(negedge clk);
    #1;
    chk("t5_no_rsp", rsp_cnt - base, 0);
    chk("t5_inflight_zero", inflight, 0);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("t5_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;

    // 6: steady-state occupancy
    do_reset();
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      if (j <= LATENCY + 1) chk("t6_ramp", inflight, j);
      else chk("t6_sat", inflight, LATENCY + 1);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LATENCY + 4) @(negedge clk);
    #1;
    chk("t6_drain", inflight, 0);
    chk("t6_err", err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
